// File: rtl/multiciclo_pc_ir_unit.sv
// PC / current-PC / IR / MDR / ALUOut state of the multicycle RV32 datapath.
// Conditional branches are resolved here from the ALU flags and IR funct3.
module multiciclo_pc_ir_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] RESET_IR   = 32'h0000_0013
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  WriteInstructionRegister,
  input  logic                  WriteCurrentPC,
  input  logic                  WritePC,
  input  logic                  PCOrigin,
  input  logic                  Branch,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] current_pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  branch_taken,
  output logic                  pc_misaligned
);

  // funct3 encodings 010/011 are not branches and never take.
  function automatic logic branch_cond(input logic [2:0] f3, input logic z,
                                       input logic lt, input logic ltu);
    logic c;
    case (f3)
      3'b000:  c = z;
      3'b001:  c = !z;
      3'b100:  c = lt;
      3'b101:  c = !lt;
      3'b110:  c = ltu;
      3'b111:  c = !ltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic [DATA_WIDTH-1:0] next_pc;
  logic                  pc_we;

  assign opcode       = instruction[6:0];
  assign funct3       = instruction[14:12];
  assign branch_taken = Branch & branch_cond(funct3, alu_zero, alu_lt, alu_ltu);
  assign next_pc      = PCOrigin ? alu_out : alu_result;
  assign pc_we        = WritePC | branch_taken;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      current_pc    <= RESET_PC;
      instruction   <= RESET_IR;
      mdr           <= '0;
      alu_out       <= '0;
      pc_misaligned <= 1'b0;
    end else begin
      mdr     <= mem_rdata;
      alu_out <= alu_result;
      if (WriteInstructionRegister) instruction <= mem_rdata;
      if (WriteCurrentPC)           current_pc  <= pc;
      // Low bits are dropped on write; a misaligned target is flagged and stays flagged.
      if (pc_we) begin
        pc <= {next_pc[DATA_WIDTH-1:2], 2'b00};
        if (next_pc[1:0] != 2'b00) pc_misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multiciclo_pc_ir_unit.sv
// Directed bench for multiciclo_pc_ir_unit: vector table plus reset sequences.
module tb_multiciclo_pc_ir_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wir, wcpc, wpc, po, br;
  logic [31:0] mem_rdata, alu_result;
  logic        alu_zero, alu_lt, alu_ltu;
  logic [31:0] pc, current_pc, instruction, mdr, alu_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken, pc_misaligned;

  int checks = 0;
  int failures = 0;

  multiciclo_pc_ir_unit dut (
    .clock(clock), .reset_n(reset_n),
    .WriteInstructionRegister(wir), .WriteCurrentPC(wcpc), .WritePC(wpc),
    .PCOrigin(po), .Branch(br), .mem_rdata(mem_rdata), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .pc(pc), .current_pc(current_pc), .instruction(instruction), .opcode(opcode),
    .funct3(funct3), .mdr(mdr), .alu_out(alu_out), .branch_taken(branch_taken),
    .pc_misaligned(pc_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wir, wcpc, wpc, po, br;
    logic [31:0] mem, alu;
    logic        z, lt, ltu;
    logic        bt;
    logic [31:0] pc, cpc, ir, mdr, aout;
    logic        mis;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wir = 0; wcpc = 0; wpc = 0; po = 0; br = 0;
    mem_rdata = '0; alu_result = '0;
    alu_zero = 0; alu_lt = 0; alu_ltu = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},   pc,          32'h0040_0000);
    chk({tag, "_cpc"},  current_pc,  32'h0040_0000);
    chk({tag, "_ir"},   instruction, 32'h0000_0013);
    chk({tag, "_op"},   {25'd0, opcode}, 32'h13);
    chk({tag, "_mdr"},  mdr,         32'h0);
    chk({tag, "_aout"}, alu_out,     32'h0);
    chk({tag, "_mis"},  {31'd0, pc_misaligned}, 32'h0);
  endtask

  initial begin
    //            wir wcpc wpc po br  mem           alu           z  lt ltu bt  pc            cpc           ir            mdr           aout          mis
    vecs[0]  = '{1, 1, 1, 0, 0, 32'h00A28263, 32'h00400004, 0, 0, 0, 0, 32'h00400004, 32'h00400000, 32'h00A28263, 32'h00A28263, 32'h00400004, 0}; // fetch BEQ
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h00000000, 32'h00400010, 0, 0, 0, 0, 32'h00400004, 32'h00400000, 32'h00A28263, 32'h0,        32'h00400010, 0}; // decode target
    vecs[2]  = '{0, 0, 0, 1, 1, 32'h00000000, 32'h12345678, 1, 0, 0, 1, 32'h00400010, 32'h00400000, 32'h00A28263, 32'h0,        32'h12345678, 0}; // BEQ taken
    vecs[3]  = '{0, 0, 0, 0, 0, 32'h00000000, 32'h00400020, 0, 0, 0, 0, 32'h00400010, 32'h00400000, 32'h00A28263, 32'h0,        32'h00400020, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 32'h00400010, 32'h00400000, 32'h00A28263, 32'h0,        32'h0,        0}; // BEQ not taken
    vecs[5]  = '{1, 1, 1, 0, 0, 32'h00006063, 32'h00400014, 0, 0, 0, 0, 32'h00400014, 32'h00400010, 32'h00006063, 32'h00006063, 32'h00400014, 0}; // fetch BLTU
    vecs[6]  = '{0, 0, 0, 0, 1, 32'h00000000, 32'h00400030, 0, 0, 1, 1, 32'h00400030, 32'h00400010, 32'h00006063, 32'h0,        32'h00400030, 0}; // BLTU taken
    vecs[7]  = '{0, 0, 0, 0, 1, 32'h00000000, 32'h00400040, 1, 1, 0, 0, 32'h00400030, 32'h00400010, 32'h00006063, 32'h0,        32'h00400040, 0}; // BLTU not taken
    vecs[8]  = '{1, 1, 1, 0, 0, 32'h00002063, 32'h00400034, 0, 0, 0, 0, 32'h00400034, 32'h00400030, 32'h00002063, 32'h00002063, 32'h00400034, 0}; // fetch funct3=010
    vecs[9]  = '{0, 0, 0, 0, 1, 32'h00000000, 32'h00400050, 1, 1, 1, 0, 32'h00400034, 32'h00400030, 32'h00002063, 32'h0,        32'h00400050, 0}; // never taken
    vecs[10] = '{0, 0, 1, 0, 0, 32'h00000000, 32'h00400006, 0, 0, 0, 0, 32'h00400004, 32'h00400030, 32'h00002063, 32'h0,        32'h00400006, 1}; // misaligned
    vecs[11] = '{0, 0, 1, 0, 1, 32'h00000000, 32'h00400020, 0, 0, 0, 0, 32'h00400020, 32'h00400030, 32'h00002063, 32'h0,        32'h00400020, 1}; // WritePC beats cond=0

    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_state("rst");
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      wir = vecs[i].wir; wcpc = vecs[i].wcpc; wpc = vecs[i].wpc;
      po = vecs[i].po; br = vecs[i].br;
      mem_rdata = vecs[i].mem; alu_result = vecs[i].alu;
      alu_zero = vecs[i].z; alu_lt = vecs[i].lt; alu_ltu = vecs[i].ltu;
      #1;
      chk($sformatf("v%0d_bt", i), {31'd0, branch_taken}, {31'd0, vecs[i].bt});
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_pc", i),   pc,          vecs[i].pc);
      chk($sformatf("v%0d_cpc", i),  current_pc,  vecs[i].cpc);
      chk($sformatf("v%0d_ir", i),   instruction, vecs[i].ir);
      chk($sformatf("v%0d_op", i),   {25'd0, opcode}, {25'd0, vecs[i].ir[6:0]});
      chk($sformatf("v%0d_f3", i),   {29'd0, funct3}, {29'd0, vecs[i].ir[14:12]});
      chk($sformatf("v%0d_mdr", i),  mdr,         vecs[i].mdr);
      chk($sformatf("v%0d_aout", i), alu_out,     vecs[i].aout);
      chk($sformatf("v%0d_mis", i),  {31'd0, pc_misaligned}, {31'd0, vecs[i].mis});
    end

    // Asynchronous reset between clock edges, with strobes still active.
    wpc = 1'b1; alu_result = 32'h00400044; mem_rdata = 32'h00000063;
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("async");
    @(negedge clock);
    drive_idle();
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_reset_state("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiciclo_pc_ir_unit.md
Name: multiciclo_pc_ir_unit

Overview:
- Sequential state-holding stage of the multicycle RV32 datapath, paired directly with the multicycle control FSM.
- Holds PC, the fetched-instruction PC (current PC), the instruction register (IR), the memory data register (MDR) and the ALU output register (ALUOut).
- Supplies `opcode` to the control FSM and consumes that FSM's WriteInstructionRegister, WriteCurrentPC, WritePC, PCOrigin and Branch strobes.
- Resolves conditional branches locally from ALU flags and IR funct3.

Parameters:
- DATA_WIDTH, 32, width of PC, IR, MDR and ALUOut.
- RESET_PC, 32'h0040_0000, PC and current-PC value after reset.
- RESET_IR, 32'h0000_0013, IR value after reset (addi x0,x0,0 NOP).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- WriteInstructionRegister  in  1  load IR from mem_rdata.
- WriteCurrentPC  in  1  copy pc into current_pc.
- WritePC  in  1  unconditional PC write.
- PCOrigin  in  1  PC source select: 0 = alu_result (live), 1 = alu_out (registered).
- Branch  in  1  conditional PC write, gated by branch condition.
- mem_rdata  in  DATA_WIDTH  memory read data; combinational read, valid in the same cycle as the address.
- alu_result  in  DATA_WIDTH  live ALU result.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed A<B.
- alu_ltu  in  1  unsigned A<B.
- pc  out  DATA_WIDTH  program counter.
- current_pc  out  DATA_WIDTH  PC of the instruction held in IR.
- instruction  out  DATA_WIDTH  IR contents.
- opcode  out  7  instruction[6:0], to control FSM.
- funct3  out  3  instruction[14:12].
- mdr  out  DATA_WIDTH  memory data register.
- alu_out  out  DATA_WIDTH  ALUOut register.
- branch_taken  out  1  combinational: Branch & cond.
- pc_misaligned  out  1  sticky misaligned-PC-write flag.

Behaviour:
- Reset (reset_n=0, asynchronous, immediate even mid-instruction):
  - pc=RESET_PC, current_pc=RESET_PC, instruction=RESET_IR.
  - mdr=0, alu_out=0, pc_misaligned=0.
  - The RESET_IR opcode (0010011) drives the control FSM through its default path back to fetch.
- opcode, funct3 and branch_taken are combinational from registers and inputs; they have no latency of their own.
- mdr<=mem_rdata every cycle, unconditionally. The value read in cycle N is available as mdr in cycle N+1 (load-save step).
- alu_out<=alu_result every cycle, unconditionally. The decode-cycle target is available in the following cycle.
- IR:
  - If WriteInstructionRegister, instruction<=mem_rdata.
  - Otherwise instruction holds its value.
- current_pc:
  - If WriteCurrentPC, current_pc<=pc, using the pre-edge value.
  - In the fetch cycle the same edge also writes pc<=alu_result (PC+4). The two registers therefore end as old PC and PC+4 respectively.
- PC source: next_pc = PCOrigin ? alu_out : alu_result.
- Branch condition (cond), from funct3:
  - 000: alu_zero
  - 001: !alu_zero
  - 100: alu_lt
  - 101: !alu_lt
  - 110: alu_ltu
  - 111: !alu_ltu
  - 010, 011: 0 (never taken)
- pc_we = WritePC | (Branch & cond). WritePC dominates: when WritePC and Branch are both 1, the PC is written regardless of cond.
- When pc_we=1:
  - pc<=next_pc with bits[1:0] forced to 00.
  - If next_pc[1:0]!=0, pc_misaligned<=1.
- pc_misaligned is sticky; only reset clears it.
- When pc_we=0, pc holds.
- No arithmetic is performed in the block. All widths are DATA_WIDTH with no extension.

Test Plan:
- Reset then release: pc=0x00400000, current_pc=0x00400000, instruction=0x00000013, opcode=0x13, mdr=0, alu_out=0, pc_misaligned=0.
- Fetch cycle (WriteInstructionRegister=WriteCurrentPC=WritePC=1, PCOrigin=0, mem_rdata=0x00A28263, alu_result=0x00400004) -> after the edge: instruction=0x00A28263, opcode=0x63, current_pc=0x00400000, pc=0x00400004.
- BEQ taken, over two cycles:
  - Decode cycle: alu_result=0x00400010.
  - Next cycle: Branch=1, PCOrigin=1, alu_zero=1, funct3=000.
  - Required: branch_taken=1, and pc=0x00400010 after the edge.
  - Repeat with alu_zero=0: pc unchanged, branch_taken=0.
- BLTU with funct3=110: alu_ltu=1 -> PC written; alu_ltu=0 -> PC held. With funct3=010 and all flags=1 -> PC held.
- WritePC=1 with alu_result=0x00400006 -> pc=0x00400004 and pc_misaligned=1. pc_misaligned stays 1 after later aligned writes until reset_n is asserted.
- Assert reset_n=0 mid-cycle with pc=0x00400020 -> outputs take their reset values immediately, without waiting for a clock edge. Simultaneous WritePC=1, Branch=1, cond=0 -> PC is written.
